// File: rtl/uart_rx_frame_ctrl_if.sv
// rtl/uart_rx_frame_ctrl_if.sv - serial line, frame configuration and frame report bundle
interface uart_rx_frame_ctrl_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int PRESC_WIDTH = 6,
    parameter int DL_W        = $clog2(DATA_WIDTH + 1)
);
    logic                   RX_IN;
    logic [PRESC_WIDTH-1:0] prescale;
    logic [DL_W-1:0]        data_len;
    logic                   PAR_EN;
    logic                   PAR_TYP;
    logic                   STOP2;
    logic [DATA_WIDTH-1:0]  P_DATA;
    logic                   Data_Valid;
    logic                   par_err;
    logic                   stp_err;
    logic                   busy;

    modport master (
        output RX_IN, prescale, data_len, PAR_EN, PAR_TYP, STOP2,
        input  P_DATA, Data_Valid, par_err, stp_err, busy
    );

    modport slave (
        input  RX_IN, prescale, data_len, PAR_EN, PAR_TYP, STOP2,
        output P_DATA, Data_Valid, par_err, stp_err, busy
    );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// rtl/uart_rx_frame_ctrl.sv - oversampled UART receiver with majority vote, parity/stop check
// Frames end at half+2 of the last stop bit so a following start bit may arrive early.
module uart_rx_frame_ctrl #(
    parameter int  DATA_WIDTH  = 8,
    parameter int  PRESC_WIDTH = 6,
    localparam int DL_W        = $clog2(DATA_WIDTH + 1)
) (
    input logic                 CLK,
    input logic                 RST,
    uart_rx_frame_ctrl_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2} state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [PRESC_WIDTH-1:0] r_edge_cnt;
    logic [PRESC_WIDTH-1:0] r_presc;
    logic [DL_W-1:0]        r_bit_cnt;
    logic [DL_W-1:0]        r_len;
    logic [DL_W-1:0]        w_len_clamped;
    logic                   r_par_en;
    logic                   r_par_typ;
    logic                   r_stop2;
    logic [DATA_WIDTH-1:0]  r_data;
    logic [DATA_WIDTH-1:0]  r_p_data;
    logic                   r_par;
    logic                   r_pe;
    logic                   r_se;
    logic                   r_s0;
    logic                   r_s1;
    logic                   r_valid;
    logic                   r_par_err;
    logic                   r_stp_err;
    logic [PRESC_WIDTH-1:0] w_half;
    logic                   w_at_s0;
    logic                   w_at_s1;
    logic                   w_at_vote;
    logic                   w_at_end;
    logic                   w_at_last;
    logic                   w_voted;
    logic                   w_last_bit;
    logic                   w_start;
    logic                   w_frame_end;

    assign w_half     = r_presc >> 1;
    assign w_at_s0    = (r_edge_cnt == w_half - PRESC_WIDTH'(1));
    assign w_at_s1    = (r_edge_cnt == w_half);
    assign w_at_vote  = (r_edge_cnt == w_half + PRESC_WIDTH'(1));
    assign w_at_end   = (r_edge_cnt == w_half + PRESC_WIDTH'(2));
    assign w_at_last  = (r_edge_cnt == r_presc - PRESC_WIDTH'(1));
    assign w_voted    = (r_s0 & r_s1) | (r_s0 & bus.RX_IN) | (r_s1 & bus.RX_IN);
    assign w_last_bit = (r_bit_cnt == r_len - DL_W'(1));

    always_comb begin
        w_len_clamped = bus.data_len;
        if (bus.data_len < DL_W'(5))
            w_len_clamped = DL_W'(5);
        else if (bus.data_len > DL_W'(DATA_WIDTH))
            w_len_clamped = DL_W'(DATA_WIDTH);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_start     = 1'b0;
        w_frame_end = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!bus.RX_IN) begin
                    w_next  = S_START;
                    w_start = 1'b1;
                end
            end
            S_START: begin
                if (w_at_vote && w_voted)
                    w_next = S_IDLE;
                else if (w_at_last)
                    w_next = S_DATA;
            end
            S_DATA: begin
                if (w_at_last && w_last_bit)
                    w_next = r_par_en ? S_PARITY : S_STOP1;
            end
            S_PARITY: begin
                if (w_at_last)
                    w_next = S_STOP1;
            end
            S_STOP1: begin
                if (r_stop2) begin
                    if (w_at_last)
                        w_next = S_STOP2;
                end else if (w_at_end) begin
                    w_next      = S_IDLE;
                    w_frame_end = 1'b1;
                end
            end
            S_STOP2: begin
                if (w_at_end) begin
                    w_next      = S_IDLE;
                    w_frame_end = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_edge_cnt <= '0;
            r_presc    <= '0;
            r_bit_cnt  <= '0;
            r_len      <= '0;
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_stop2    <= 1'b0;
            r_data     <= '0;
            r_p_data   <= '0;
            r_par      <= 1'b0;
            r_pe       <= 1'b0;
            r_se       <= 1'b0;
            r_s0       <= 1'b0;
            r_s1       <= 1'b0;
            r_valid    <= 1'b0;
            r_par_err  <= 1'b0;
            r_stp_err  <= 1'b0;
        end else begin
            r_valid   <= 1'b0;
            r_par_err <= 1'b0;
            r_stp_err <= 1'b0;

            // Detection cycle is edge 0 of the start bit.
            if (w_start)
                r_edge_cnt <= PRESC_WIDTH'(1);
            else if (r_state == S_IDLE || w_next == S_IDLE || w_at_last)
                r_edge_cnt <= '0;
            else
                r_edge_cnt <= r_edge_cnt + PRESC_WIDTH'(1);

            if (r_state == S_DATA) begin
                if (w_at_last && !w_last_bit)
                    r_bit_cnt <= r_bit_cnt + DL_W'(1);
            end else begin
                r_bit_cnt <= '0;
            end

            if (r_state != S_IDLE) begin
                if (w_at_s0)
                    r_s0 <= bus.RX_IN;
                if (w_at_s1)
                    r_s1 <= bus.RX_IN;
            end

            if (w_start) begin
                r_presc   <= bus.prescale;
                r_len     <= w_len_clamped;
                r_par_en  <= bus.PAR_EN;
                r_par_typ <= bus.PAR_TYP;
                r_stop2   <= bus.STOP2;
                r_data    <= '0;
                r_par     <= 1'b0;
                r_pe      <= 1'b0;
                r_se      <= 1'b0;
            end

            if (w_at_vote) begin
                case (r_state)
                    S_DATA: begin
                        for (int i = 0; i < DATA_WIDTH; i++)
                            if (r_bit_cnt == DL_W'(i))
                                r_data[i] <= w_voted;
                        r_par <= r_par ^ w_voted;
                    end
                    S_PARITY: r_pe <= r_par ^ w_voted ^ r_par_typ;
                    S_STOP1, S_STOP2: begin
                        if (!w_voted)
                            r_se <= 1'b1;
                    end
                    default: ;
                endcase
            end

            if (w_frame_end) begin
                if (!r_pe && !r_se) begin
                    r_valid  <= 1'b1;
                    r_p_data <= r_data;
                end else begin
                    r_par_err <= r_pe;
                    r_stp_err <= r_se;
                end
            end
        end
    end

    assign bus.P_DATA     = r_p_data;
    assign bus.Data_Valid = r_valid;
    assign bus.par_err    = r_par_err;
    assign bus.stp_err    = r_stp_err;
    assign bus.busy       = (r_state != S_IDLE);
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb/tb_uart_rx_frame_ctrl.sv - scoreboard bench for uart_rx_frame_ctrl
module tb_uart_rx_frame_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   fails  = 0;

    typedef struct packed {
        logic       v;
        logic       pe;
        logic       se;
        logic [7:0] d;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] last_pdata = 8'h00;

    always #5 clk = ~clk;

    uart_rx_frame_ctrl_if #(.DATA_WIDTH(8), .PRESC_WIDTH(6)) u_if ();

    uart_rx_frame_ctrl #(.DATA_WIDTH(8), .PRESC_WIDTH(6)) u_dut (
        .CLK (clk),
        .RST (rst),
        .bus (u_if)
    );

    always @(negedge clk) begin
        if (u_if.Data_Valid || u_if.par_err || u_if.stp_err) begin
            exp_t e;
            exp_t o;
            o = '{v: u_if.Data_Valid, pe: u_if.par_err, se: u_if.stp_err, d: u_if.P_DATA};
            checks++;
            assert (sb.size() > 0) else begin
                fails++;
                $error("FAIL unexpected_pulse observed=%h expected=none", o);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                assert (o === e) else begin
                    fails++;
                    $error("FAIL frame_result observed v/pe/se/data=%b%b%b/%h expected=%b%b%b/%h",
                           o.v, o.pe, o.se, o.d, e.v, e.pe, e.se, e.d);
                end
                checks++;
                assert (u_if.busy === 1'b0) else begin
                    fails++;
                    $error("FAIL busy_at_pulse observed=%b expected=0", u_if.busy);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic set_cfg(input int p, input int l, input bit pe, input bit pt, input bit s2);
        u_if.prescale = 6'(p);
        u_if.data_len = 4'(l);
        u_if.PAR_EN   = pe;
        u_if.PAR_TYP  = pt;
        u_if.STOP2    = s2;
    endtask

    task automatic idle(input int n);
        u_if.RX_IN = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input bit v, input bit pe, input bit se, input logic [7:0] d);
        if (v)
            last_pdata = d;
        sb.push_back('{v: v, pe: pe, se: se, d: (v ? d : last_pdata)});
    endtask

    task automatic send_frame(input logic [7:0] d, input int len, input int presc,
                              input bit par_en, input bit par_typ, input bit par_flip,
                              input bit stop2, input bit s1v, input bit s2v,
                              input int flip_bit, input int flip_cyc, input int trim);
        logic bits[$];
        logic x;
        x = 1'b0;
        bits.push_back(1'b0);
        for (int i = 0; i < len; i++) begin
            bits.push_back(d[i]);
            x = x ^ d[i];
        end
        if (par_en)
            bits.push_back(x ^ par_typ ^ par_flip);
        bits.push_back(s1v);
        if (stop2)
            bits.push_back(s2v);
        for (int b = 0; b < bits.size(); b++) begin
            int n;
            n = (b == bits.size() - 1) ? presc - trim : presc;
            for (int c = 0; c < n; c++) begin
                u_if.RX_IN = (b == flip_bit && c == flip_cyc) ? ~bits[b] : bits[b];
                @(negedge clk);
            end
        end
        u_if.RX_IN = 1'b1;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (sb.size() == 0) else begin
            fails++;
            $error("FAIL drain_%s observed=%0d pending expected=0", tag, sb.size());
        end
    endtask

    task automatic check_quiet(input string tag);
        logic [11:0] o;
        o = {u_if.P_DATA, u_if.Data_Valid, u_if.par_err, u_if.stp_err, u_if.busy};
        checks++;
        assert (o === 12'h000) else begin
            fails++;
            $error("FAIL %s observed=%h expected=000", tag, o);
        end
    endtask

    initial begin
        u_if.RX_IN = 1'b1;
        set_cfg(8, 8, 0, 0, 0);
        repeat (3) @(negedge clk);
        check_quiet("reset_state");
        rst = 1'b0;
        idle(4);

        push_exp(1, 0, 0, 8'h55);
        send_frame(8'h55, 8, 8, 0, 0, 0, 0, 1, 1, -1, 0, 0);
        wait_drain("0x55");
        idle(4);

        set_cfg(16, 8, 1, 0, 0);
        push_exp(1, 0, 0, 8'hA3);
        send_frame(8'hA3, 8, 16, 1, 0, 0, 0, 1, 1, -1, 0, 0);
        wait_drain("even_ok");
        idle(4);
        push_exp(0, 1, 0, 8'h00);
        send_frame(8'hA3, 8, 16, 1, 0, 1, 0, 1, 1, -1, 0, 0);
        wait_drain("even_bad");
        idle(4);
        set_cfg(16, 8, 1, 1, 0);
        push_exp(1, 0, 0, 8'h5C);
        send_frame(8'h5C, 8, 16, 1, 1, 0, 0, 1, 1, -1, 0, 0);
        wait_drain("odd_ok");
        idle(4);

        set_cfg(8, 8, 0, 0, 0);
        u_if.RX_IN = 1'b0;
        @(negedge clk);
        @(negedge clk);
        u_if.RX_IN = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        assert (u_if.busy === 1'b1) else begin
            fails++;
            $error("FAIL glitch_busy_before observed=%b expected=1", u_if.busy);
        end
        @(negedge clk);
        checks++;
        assert (u_if.busy === 1'b0) else begin
            fails++;
            $error("FAIL glitch_idle observed=%b expected=0", u_if.busy);
        end
        idle(20);

        set_cfg(8, 7, 0, 0, 1);
        push_exp(0, 0, 1, 8'h00);
        send_frame(8'h7F, 7, 8, 0, 0, 0, 1, 1, 0, -1, 0, 0);
        wait_drain("stop2_low");
        idle(30);

        set_cfg(8, 8, 0, 0, 0);
        push_exp(1, 0, 0, 8'h00);
        send_frame(8'h00, 8, 8, 0, 0, 0, 0, 1, 1, 4, 4, 0);
        wait_drain("majority");
        idle(4);

        set_cfg(8, 2, 0, 0, 0);
        push_exp(1, 0, 0, 8'h15);
        send_frame(8'h15, 5, 8, 0, 0, 0, 0, 1, 1, -1, 0, 0);
        wait_drain("clamp_low");
        idle(4);
        set_cfg(8, 15, 0, 0, 0);
        push_exp(1, 0, 0, 8'hC3);
        send_frame(8'hC3, 8, 8, 0, 0, 0, 0, 1, 1, -1, 0, 0);
        wait_drain("clamp_high");
        idle(4);

        set_cfg(8, 8, 1, 0, 0);
        push_exp(0, 1, 1, 8'h00);
        send_frame(8'h0F, 8, 8, 1, 0, 1, 0, 0, 1, -1, 0, 0);
        wait_drain("both_err");
        idle(30);

        set_cfg(8, 8, 0, 0, 0);
        push_exp(1, 0, 0, 8'h12);
        push_exp(1, 0, 0, 8'h34);
        send_frame(8'h12, 8, 8, 0, 0, 0, 0, 1, 1, -1, 0, 2);
        send_frame(8'h34, 8, 8, 0, 0, 0, 0, 1, 1, -1, 0, 0);
        wait_drain("back_to_back");
        idle(4);

        u_if.RX_IN = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            u_if.RX_IN = (i == 1);
            repeat (8) @(negedge clk);
        end
        u_if.RX_IN = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check_quiet("reset_mid_frame");
        @(negedge clk);
        rst = 1'b0;
        last_pdata = 8'h00;
        idle(20);
        check_quiet("after_reset_idle");

        push_exp(1, 0, 0, 8'h9C);
        send_frame(8'h9C, 8, 8, 0, 0, 0, 0, 1, 1, -1, 0, 0);
        wait_drain("post_reset");
        idle(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
Parametrised next-generation UART receive controller for the low-power multi-clock system. It replaces the external edge/bit counter plus check-block arrangement with one self-contained block. The block holds the bit-timing counters, 3-sample majority voting, deserialisation, parity and stop checking, and a one-cycle valid/error report. It adds generalisations the current receiver lacks: configurable word width, runtime data length (5..DATA_WIDTH), odd/even parity, two stop bits, and early return to IDLE for drift-tolerant back-to-back frames.

Parameters:
DATA_WIDTH, 8, maximum data bits per frame; width of P_DATA
PRESC_WIDTH, 6, width of prescale input and edge counter
DL_W, $clog2(DATA_WIDTH+1), width of data_len (derived, not overridden)

Ports:
CLK  input  1  receiver oversampling clock
RST  input  1  asynchronous, active-high reset
RX_IN  input  1  serial line, idle high (already synchronised upstream)
prescale  input  PRESC_WIDTH  oversampling ratio; even, 6..2^PRESC_WIDTH-2
data_len  input  DL_W  data bits per frame
PAR_EN  input  1  1 = parity bit present
PAR_TYP  input  1  0 = even, 1 = odd
STOP2  input  1  1 = two stop bits
P_DATA  output  DATA_WIDTH  received word, LSB = first data bit, unused MSBs zero
Data_Valid  output  1  one-cycle pulse, frame good
par_err  output  1  one-cycle pulse, parity mismatch
stp_err  output  1  one-cycle pulse, stop bit sampled low
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset: one clock; asynchronous and active-high. All outputs are 0, state is IDLE, and all counters are 0. Reset asserted mid-frame aborts the frame with no pulses. After release, the block waits in IDLE for the next low on RX_IN.
- Derived values: half = prescale>>1. edge_cnt runs 0..prescale-1 within each bit. bit_cnt indexes data bits.
- Config latching: prescale, data_len, PAR_EN, PAR_TYP and STOP2 are latched on IDLE->START. Changes mid-frame are ignored.
- data_len clamping: values <5 act as 5; values >DATA_WIDTH act as DATA_WIDTH.
- Sampling: RX_IN is captured at edge_cnt = half-1 and half. At edge_cnt = half+1 the voted bit is the majority of those two samples and the current RX_IN. All decisions below use the voted bit at half+1.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2.
- IDLE: RX_IN=0 -> START. The detection cycle counts as edge 0, so edge_cnt=1 in the first START cycle. The internal data register is cleared.
- START: voted bit 1 at half+1 -> glitch, back to IDLE with no pulses. Otherwise at edge_cnt=prescale-1 -> DATA with bit_cnt=0.
- DATA:
  - At half+1 the voted bit is written to data_reg[bit_cnt], and running parity is XORed with it.
  - At prescale-1: if bit_cnt = len-1, go to PARITY when PAR_EN=1, else STOP1. Otherwise bit_cnt increments.
- PARITY: at half+1 an internal flag pe is set if (running parity XOR voted bit XOR PAR_TYP) != 0. At prescale-1 -> STOP1.
- STOP1: at half+1 a voted 0 sets internal flag se.
  - STOP2 latched=1: go to STOP2 at prescale-1.
  - STOP2 latched=0: the frame ends at half+2.
- STOP2 state: same stop-bit check; the frame ends at half+2.
- Frame end (half+2 of the final stop bit):
  - Pulses are exactly one cycle, and the state returns to IDLE in the same cycle without waiting for the remainder of the stop bit.
  - pe=0 and se=0: Data_Valid=1 and P_DATA loaded from data_reg in the same cycle.
  - Otherwise: par_err=pe and stp_err=se pulse (both may be set together); Data_Valid stays 0 and P_DATA is unchanged.
- Back-to-back frames: after frame end, a low RX_IN seen in IDLE starts the next frame immediately.
- P_DATA holds its value between frames.
- Counter width: edge_cnt is PRESC_WIDTH bits and never wraps within a legal prescale.
- Illegal prescale (odd or <6): behaviour is undefined. The bench must not drive it.

Test Plan:
- prescale=8, data_len=8, PAR_EN=0, STOP2=0, frame 0x55 -> Data_Valid pulses once, P_DATA=0x55, no error pulses; busy drops the same cycle.
- prescale=16, PAR_EN=1, PAR_TYP=0, frame 0xA3 with correct parity bit 0, then same frame with parity bit 1 -> first gives Data_Valid with P_DATA=0xA3; second gives par_err only, P_DATA stays 0xA3.
- RX_IN low for 2 cycles then high (prescale=8) -> state returns to IDLE at edge half+1 of START; no pulses; busy low afterwards.
- data_len=7, STOP2=1, frame 0x7F with second stop bit low -> stp_err pulses at half+2 of the second stop bit; no Data_Valid.
- One flipped sample at edge half inside data bit 3 of 0x00 -> majority vote rejects it; Data_Valid with P_DATA=0x00.
- Two frames 0x12, 0x34 back-to-back with the next start bit beginning 2 cycles before the nominal end of the stop bit; then RST pulsed mid-data of a third frame -> 0x12 and 0x34 are each received correctly; after RST all outputs are 0, no pulse for the aborted frame, and the next clean frame is received correctly.
